// File: rtl/seconds_timebase.sv
// seconds_timebase: first stage of the clock chain.
// Divides clk down to a 1 Hz (or FAST_HZ) tick, counts seconds 0..59 and
// drives inc_mins, whose falling edge advances the downstream minutes counter.
// A debounced "advance minute" pushbutton adds manual minute strobes.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   run       in   1 = prescaler/seconds count, 0 = frozen
//   fast      in   1 = tick at FAST_HZ instead of 1 Hz
//   sec_clr   in   synchronous clear of seconds and prescaler
//   btn_min   in   raw bouncing pushbutton, 1 = pressed
//   tick_1hz  out  one-cycle pulse per seconds increment
//   seconds   out  current seconds, 0..59
//   inc_mins  out  minute strobe, falling edge = one minute downstream
module seconds_timebase #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned FAST_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAN_PULSE       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       fast,
  input  logic       sec_clr,
  input  logic       btn_min,
  output logic       tick_1hz,
  output logic [5:0] seconds,
  output logic       inc_mins
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STR_W = $clog2(MAN_PULSE + 1);
  localparam int unsigned SEC_W = 6;

  localparam logic [PRE_W-1:0] PRE_LAST_SLOW = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_LAST_FAST = PRE_W'((CLK_HZ / FAST_HZ) - 1);
  localparam logic [DB_W-1:0]  DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD      = STR_W'(MAN_PULSE);
  localparam logic [SEC_W-1:0] SEC_LAST      = SEC_W'(59);
  localparam logic [SEC_W-1:0] SEC_GUARD     = SEC_W'(57);

  // State registers
  logic [PRE_W-1:0] prescaler;
  logic             sync_1;
  logic             sync_2;
  logic             db_level;
  logic             db_prev;
  logic [DB_W-1:0]  db_cnt;
  logic [STR_W-1:0] str_cnt;

  // Next-state values
  logic [PRE_W-1:0] pre_next;
  logic [SEC_W-1:0] sec_next;
  logic             tick_next;
  logic             db_level_next;
  logic [DB_W-1:0]  db_cnt_next;
  logic [STR_W-1:0] str_next;
  logic             inc_next;

  // Combinational helpers
  logic [PRE_W-1:0] pre_last_c;
  logic             wrap_c;
  logic             press_c;
  logic             accept_c;

  // Prescaler and seconds counter; sec_clr outranks a tick in the same cycle.
  always_comb begin
    pre_next  = prescaler;
    sec_next  = seconds;
    tick_next = 1'b0;
    pre_last_c = fast ? PRE_LAST_FAST : PRE_LAST_SLOW;
    // >= rather than == so enabling fast with a large prescaler ticks at once
    wrap_c = run && (prescaler >= pre_last_c);
    if (sec_clr) begin
      pre_next = '0;
      sec_next = '0;
    end else if (run) begin
      if (wrap_c) begin
        pre_next  = '0;
        tick_next = 1'b1;
        sec_next  = (seconds == SEC_LAST) ? '0 : seconds + SEC_W'(1);
      end else begin
        pre_next = prescaler + PRE_W'(1);
      end
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    db_level_next = db_level;
    db_cnt_next   = '0;
    if (sync_2 != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level_next = sync_2;
        db_cnt_next   = '0;
      end else begin
        db_cnt_next = db_cnt + DB_W'(1);
      end
    end
  end

  // Manual stretch; presses late in the minute are dropped so the stretch
  // can never merge with the automatic seconds==59 strobe.
  always_comb begin
    press_c  = db_level & ~db_prev;
    accept_c = press_c && (str_cnt == '0) && (seconds <= SEC_GUARD);
    str_next = str_cnt;
    if (accept_c) begin
      str_next = STR_LOAD;
    end else if (str_cnt != '0) begin
      str_next = str_cnt - STR_W'(1);
    end
    // Built from next-state values so inc_mins moves on the same edge as seconds
    inc_next = (sec_next == SEC_LAST) || (str_next != '0);
  end

  // Register bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      seconds   <= '0;
      tick_1hz  <= 1'b0;
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      db_level  <= 1'b0;
      db_prev   <= 1'b0;
      db_cnt    <= '0;
      str_cnt   <= '0;
      inc_mins  <= 1'b0;
    end else begin
      prescaler <= pre_next;
      seconds   <= sec_next;
      tick_1hz  <= tick_next;
      sync_1    <= btn_min;
      sync_2    <= sync_1;
      db_level  <= db_level_next;
      db_prev   <= db_level;
      db_cnt    <= db_cnt_next;
      str_cnt   <= str_next;
      inc_mins  <= inc_next;
    end
  end

endmodule
